// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and helpers for the seven-segment display path
package seg_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [3:0] CODE_DASH = 4'd10;
    localparam logic [3:0] CODE_R    = 4'd11;
    localparam logic [3:0] CODE_E    = 4'd14;

    // Codes without a decoder glyph are shown as a dash.
    function automatic logic [3:0] sanitise_code(input logic [3:0] c);
        case (c)
            4'd12, 4'd13, 4'd15: sanitise_code = CODE_DASH;
            default:             sanitise_code = c;
        endcase
    endfunction

    // Digit 0 is the leftmost nibble of the display word.
    function automatic logic [3:0] digit_of(input logic [15:0] w, input logic [1:0] s);
        case (s)
            2'd0:    digit_of = w[15:12];
            2'd1:    digit_of = w[11:8];
            2'd2:    digit_of = w[7:4];
            default: digit_of = w[3:0];
        endcase
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// rtl/refresh_prescaler.sv - free-running modulo-REFRESH_DIV counter with terminal-count tick
module refresh_prescaler #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - 4-digit display multiplexer with frame-aligned word commit; optional SEG_SCAN_ERR_OVERRIDE_EN
module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        load,
    input  logic        err,
    output logic [1:0]  sel,
    output logic [3:0]  code,
    output logic        upd_pending,
    output logic        frame_start
);

    logic        w_tick;
    logic        w_wrap;
    logic [1:0]  w_next_sel;
    logic [15:0] w_next_active;
    logic [3:0]  w_next_code;
    logic [15:0] r_active;
    logic [15:0] r_shadow;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

`ifndef SEG_SCAN_ERR_OVERRIDE_EN
    logic w_unused_err;
    assign w_unused_err = err;
`endif

    // code is derived from next-state sel/active so both registers update together.
    always_comb begin
        w_wrap        = w_tick && (sel == 2'd3);
        w_next_sel    = w_tick ? sel + 2'd1 : sel;
        w_next_active = r_active;
        if (w_wrap) begin
            if (load) begin
                w_next_active = din;
            end else if (upd_pending) begin
                w_next_active = r_shadow;
            end
        end
        w_next_code = sanitise_code(digit_of(w_next_active, w_next_sel));
`ifdef SEG_SCAN_ERR_OVERRIDE_EN
        if (err) begin
            case (w_next_sel)
                2'd0:    w_next_code = CODE_E;
                2'd1:    w_next_code = CODE_R;
                2'd2:    w_next_code = CODE_R;
                default: w_next_code = CODE_DASH;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel         <= 2'd0;
            code        <= 4'd0;
            upd_pending <= 1'b0;
            frame_start <= 1'b0;
            r_active    <= 16'h0000;
            r_shadow    <= 16'h0000;
        end else begin
            sel         <= w_next_sel;
            code        <= w_next_code;
            frame_start <= w_wrap;
            r_active    <= w_next_active;
            if (w_wrap) begin
                upd_pending <= 1'b0;
            end else if (load) begin
                r_shadow    <= din;
                upd_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - directed self-checking bench for seg_display_scanner (REFRESH_DIV=4)
module tb_seg_display_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic        err;
    logic [1:0]  sel;
    logic [3:0]  code;
    logic        upd_pending;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int fs_cnt;
    int exp_frame[4];

    seg_display_scanner #(
        .REFRESH_DIV (4),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load        (load),
        .err         (err),
        .sel         (sel),
        .code        (code),
        .upd_pending (upd_pending),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        din  = 16'h0000;
        err  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_rst_sel", 16'(sel), 0);
        check("in_rst_code", 16'(code), 0);
        rst = 1'b0;
        check("rel_sel", 16'(sel), 0);
        check("rel_code", 16'(code), 0);
        check("rel_pend", 16'(upd_pending), 0);
        check("rel_fs", 16'(frame_start), 0);

        // Rotation: sel steps every 4 cycles, frame_start once at the wrap.
        fs_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("rot_sel", 16'(sel), 16'((k / 4) % 4));
            if (frame_start) fs_cnt++;
        end
        check("fs_count", 16'(fs_cnt), 1);
        check("fs_at_wrap", 16'(frame_start), 1);

        // Load mid-frame at sel=1.
        repeat (4) step();
        check("mid_sel", 16'(sel), 1);
        din = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        check("mid_pend", 16'(upd_pending), 1);
        check("mid_code_old", 16'(code), 0);
        repeat (11) step();
        check("commit_fs", 16'(frame_start), 1);
        check("commit_sel", 16'(sel), 0);
        check("commit_code0", 16'(code), 1);
        check("commit_pend", 16'(upd_pending), 0);
        for (int s = 1; s < 4; s++) begin
            repeat (4) step();
            check("commit_code", 16'(code), 16'(s + 1));
        end
        repeat (4) step();
        check("frame2_code0", 16'(code), 1);

        // Double load: last write wins.
        repeat (2) step();
        din = 16'h1111; load = 1'b1;
        step();
        din = 16'h5678;
        step();
        load = 1'b0;
        check("dbl_pend", 16'(upd_pending), 1);
        check("dbl_code_old", 16'(code), 2);
        repeat (12) step();
        exp_frame = '{5, 6, 7, 8};
        for (int i = 0; i < 16; i++) begin
            check("dbl_code", 16'(code), 16'(exp_frame[i / 4]));
            step();
        end
        check("dbl_pend_clr", 16'(upd_pending), 0);

        // Load coinciding with the frame wrap goes straight to active.
        repeat (15) step();
        check("wrapld_sel3", 16'(sel), 3);
        din = 16'h9876; load = 1'b1;
        step();
        load = 1'b0;
        check("wrapld_sel", 16'(sel), 0);
        check("wrapld_code", 16'(code), 9);
        check("wrapld_pend", 16'(upd_pending), 0);
        check("wrapld_fs", 16'(frame_start), 1);

        // Sanitise: 0xCDEF shows as dash, dash, E, dash.
        din = 16'hCDEF; load = 1'b1;
        step();
        load = 1'b0;
        check("san_pend", 16'(upd_pending), 1);
        check("san_code_old", 16'(code), 9);
        repeat (15) step();
        exp_frame = '{10, 10, 14, 10};
        for (int i = 0; i < 16; i++) begin
            check("san_code", 16'(code), 16'(exp_frame[i / 4]));
            step();
        end

`ifdef SEG_SCAN_ERR_OVERRIDE_EN
        err = 1'b1;
        step();
        exp_frame = '{14, 11, 11, 10};
        for (int i = 1; i < 16; i++) begin
            check("err_code", 16'(code), 16'(exp_frame[i / 4]));
            check("err_sel", 16'(sel), 16'(i / 4));
            step();
        end
        check("err_wrap_code", 16'(code), 14);
        err = 1'b0;
        step();
        check("err_drop_code", 16'(code), 10);
        repeat (15) step();
`endif

        // Reset mid-frame with a pending word.
        repeat (5) step();
        din = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        check("pre_rst_pend", 16'(upd_pending), 1);
        check("pre_rst_sel", 16'(sel), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_sel", 16'(sel), 0);
        check("async_code", 16'(code), 0);
        check("async_pend", 16'(upd_pending), 0);
        check("async_fs", 16'(frame_start), 0);
        din = 16'h1234; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b0;
        check("rstld_pend", 16'(upd_pending), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("post_rst_code", 16'(code), 0);
        end
        check("post_rst_fs", 16'(frame_start), 1);
        check("post_rst_pend", 16'(upd_pending), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
